// File: rtl/vga_sync_tracker.sv
// ============================================================================
// Module   : vga_sync_tracker
// Purpose  : Follows external Hsync/Vsync, regenerates column/row counters and
//            qualifies frame length with a lock FSM. VGA_SYNC_FLYWHEEL_EN lets
//            a single missed frame pass while locked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_tracker #(
  parameter int unsigned TOTAL_COLS  = 800,
  parameter int unsigned TOTAL_ROWS  = 525,
  parameter int unsigned ACTIVE_COLS = 640,
  parameter int unsigned ACTIVE_ROWS = 480,
  parameter int unsigned COL_W       = 10,
  parameter int unsigned ROW_W       = 10,
  parameter int unsigned FRAME_W     = 8,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               Hsync_i,
  input  logic               Vsync_i,
  output logic               Hsync_o,
  output logic               Vsync_o,
  output logic [COL_W-1:0]   col_count_o,
  output logic [ROW_W-1:0]   row_count_o,
  output logic               active_o,
  output logic [FRAME_W-1:0] frame_count_o,
  output logic               frame_start_o,
  output logic               locked_o
);

  localparam logic [COL_W-1:0] c_COL_LAST    = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST    = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [COL_W:0]   c_ACT_COLS    = (COL_W + 1)'(ACTIVE_COLS);
  localparam logic [ROW_W:0]   c_ACT_ROWS    = (ROW_W + 1)'(ACTIVE_ROWS);
  localparam logic [3:0]       c_LOCK_FRAMES = 4'(LOCK_FRAMES);

  typedef enum logic [0:0] {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_hsync;
  logic               r_vsync;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_frame_start;
  logic               r_locked;
  logic               r_seen_edge;
  logic [3:0]         r_good_cnt;
`ifdef VGA_SYNC_FLYWHEEL_EN
  logic               r_miss;
`endif

  logic       w_edge;
  logic       w_col_last;
  logic       w_at_wrap;
  logic       w_good;
  logic [3:0] w_good_nxt;

  // Comparing against the already-delayed Vsync keeps the edge aligned with Vsync_o.
  assign w_edge     = Vsync_i & ~r_vsync;
  assign w_col_last = (r_col == c_COL_LAST);
  assign w_at_wrap  = w_col_last & (r_row == c_ROW_LAST);
  assign w_good     = w_edge & w_at_wrap & r_seen_edge;
  assign w_good_nxt = r_good_cnt + 4'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_SEARCH;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_seen_edge   <= 1'b0;
      r_good_cnt    <= 4'd0;
`ifdef VGA_SYNC_FLYWHEEL_EN
      r_miss        <= 1'b0;
`endif
    end else begin
      r_hsync       <= Hsync_i;
      r_vsync       <= Vsync_i;
      r_frame_start <= 1'b0;

      if (w_edge) begin
        r_seen_edge <= 1'b1;
      end

      if (w_edge || w_at_wrap) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end

      case (r_state)
        S_SEARCH: begin
          if (w_good) begin
            if (w_good_nxt == c_LOCK_FRAMES) begin
              r_state       <= S_LOCKED;
              r_locked      <= 1'b1;
              r_good_cnt    <= 4'd0;
              r_frame_start <= 1'b1;
              r_frame_cnt   <= r_frame_cnt + 1'b1;
            end else begin
              r_good_cnt <= w_good_nxt;
            end
          end else if (w_edge || w_at_wrap) begin
            r_good_cnt <= 4'd0;
          end
        end

        S_LOCKED: begin
          if (w_good) begin
            r_frame_start <= 1'b1;
            r_frame_cnt   <= r_frame_cnt + 1'b1;
`ifdef VGA_SYNC_FLYWHEEL_EN
            r_miss        <= 1'b0;
`endif
          end else if (w_edge) begin
            r_state    <= S_SEARCH;
            r_locked   <= 1'b0;
            r_good_cnt <= 4'd0;
`ifdef VGA_SYNC_FLYWHEEL_EN
            r_miss     <= 1'b0;
`endif
          end else if (w_at_wrap) begin
`ifdef VGA_SYNC_FLYWHEEL_EN
            // Coast through one missing Vsync; two in a row means the source is gone.
            if (!r_miss) begin
              r_miss <= 1'b1;
            end else begin
              r_state    <= S_SEARCH;
              r_locked   <= 1'b0;
              r_good_cnt <= 4'd0;
              r_miss     <= 1'b0;
            end
`else
            r_state    <= S_SEARCH;
            r_locked   <= 1'b0;
            r_good_cnt <= 4'd0;
`endif
          end
        end

        default: begin
          r_state  <= S_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign Hsync_o       = r_hsync;
  assign Vsync_o       = r_vsync;
  assign col_count_o   = r_col;
  assign row_count_o   = r_row;
  assign frame_count_o = r_frame_cnt;
  assign frame_start_o = r_frame_start;
  assign locked_o      = r_locked;
  assign active_o      = r_locked & ({1'b0, r_col} < c_ACT_COLS) & ({1'b0, r_row} < c_ACT_ROWS);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_tracker.sv
// ============================================================================
// Module   : tb_vga_sync_tracker
// Purpose  : Scoreboard bench for vga_sync_tracker on an 8x4 (32-cycle) frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_tracker;

  localparam int TC  = 8;
  localparam int TR  = 4;
  localparam int AC  = 6;
  localparam int AR  = 3;
  localparam int CW  = 3;
  localparam int RW  = 2;
  localparam int FW  = 4;
  localparam int LF  = 2;
  localparam int LEN = TC * TR;

  logic          clk_i   = 1'b0;
  logic          rst_i   = 1'b1;
  logic          Hsync_i = 1'b0;
  logic          Vsync_i = 1'b0;
  logic          Hsync_o;
  logic          Vsync_o;
  logic [CW-1:0] col_count_o;
  logic [RW-1:0] row_count_o;
  logic          active_o;
  logic [FW-1:0] frame_count_o;
  logic          frame_start_o;
  logic          locked_o;

  vga_sync_tracker #(
    .TOTAL_COLS (TC), .TOTAL_ROWS (TR), .ACTIVE_COLS (AC), .ACTIVE_ROWS (AR),
    .COL_W (CW), .ROW_W (RW), .FRAME_W (FW), .LOCK_FRAMES (LF)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .Hsync_i       (Hsync_i),
    .Vsync_i       (Vsync_i),
    .Hsync_o       (Hsync_o),
    .Vsync_o       (Vsync_o),
    .col_count_o   (col_count_o),
    .row_count_o   (row_count_o),
    .active_o      (active_o),
    .frame_count_o (frame_count_o),
    .frame_start_o (frame_start_o),
    .locked_o      (locked_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  // Reference model: position is a single index into the frame, lock is a streak count.
  int m_pos, m_streak, m_frames;
  bit m_vs_d, m_hs_d, m_seen, m_locked, m_miss, m_fs;

  task automatic model_step(input bit v, input bit h, input bit r);
    bit edge_seen, at_end;
    if (r) begin
      m_pos = 0; m_streak = 0; m_frames = 0;
      m_vs_d = 0; m_hs_d = 0; m_seen = 0; m_locked = 0; m_miss = 0; m_fs = 0;
      return;
    end
    edge_seen = v && !m_vs_d;
    at_end    = (m_pos == LEN - 1);
    m_fs      = 0;
    if (edge_seen) begin
      if (at_end && m_seen) begin
        if (m_locked) begin
          m_miss = 0; m_fs = 1; m_frames++;
        end else begin
          m_streak++;
          if (m_streak >= LF) begin
            m_locked = 1; m_streak = 0; m_fs = 1; m_frames++;
          end
        end
      end else begin
        m_locked = 0; m_streak = 0; m_miss = 0;
      end
      m_pos  = 0;
      m_seen = 1;
    end else begin
      m_pos = (m_pos + 1) % LEN;
      if (at_end) begin
        if (!m_locked) m_streak = 0;
`ifdef VGA_SYNC_FLYWHEEL_EN
        else if (!m_miss) m_miss = 1;
`endif
        else begin
          m_locked = 0; m_streak = 0; m_miss = 0;
        end
      end
    end
    m_vs_d = v;
    m_hs_d = h;
  endtask

  function automatic logic [13:0] model_out();
    int  col = m_pos % TC;
    int  row = m_pos / TC;
    bit  act = m_locked && (col < AC) && (row < AR);
    return {m_hs_d, m_vs_d, CW'(col), RW'(row), act, FW'(m_frames), m_fs, m_locked};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit r);
    bit h;
    @(negedge clk_i);
    h       = 1'($urandom % 2);
    Hsync_i = h;
    Vsync_i = v;
    rst_i   = r;
    model_step(v, h, r);
    exp_q.push_back(model_out());
  endtask

  // One Vsync period of len cycles, starting with a rising edge.
  task automatic frame(input int len, input bit count_active);
    int w   = int'($urandom_range(1, 3));
    int act = 0;
    for (int i = 0; i < len; i++) begin
      drive(i < w, 1'b0);
      if (active_o) act++;
    end
    if (count_active) chk("active_cycles_per_frame", act, AC * AR);
  endtask

  // Monitor: one output word per clock, compared just after the edge.
  always begin
    logic [13:0] e, a;
    @(posedge clk_i);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {Hsync_o, Vsync_o, col_count_o, row_count_o, active_o,
           frame_count_o, frame_start_o, locked_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got=%h exp=%h (hs vs col row act fcnt fs lock)",
                 $time, a, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[7] = '{30, 31, 32, 32, 32, 33, 64};
    bit h;
    model_step(0, 0, 1);
    drive(0, 1);
    drive(0, 1);
    repeat (5) drive(0, 0);

    repeat (3) frame(LEN, 0);          // lock on third edge
    frame(LEN, 1);                      // active window count
    repeat (16) frame(LEN, 0);          // frame counter wrap
    frame(LEN - 5, 0);                  // early edge drops lock
    repeat (3) frame(LEN, 0);
    frame(2 * LEN, 0);                  // one withheld edge
    repeat (3) frame(LEN, 0);
    frame(3 * LEN, 0);                  // two consecutive misses
    repeat (3) frame(LEN, 0);
    repeat (20) frame(lens[$urandom_range(0, 6)], 0);
    repeat (4) frame(LEN, 0);

    // Walk to col 3, row 2 and reset between clock edges.
    for (int i = 0; i < 2 * TC + 4; i++) drive(i < 2, 1'b0);
    @(negedge clk_i);
    h       = 1'($urandom % 2);
    Hsync_i = h;
    Vsync_i = 1'b0;
    model_step(0, h, 1);
    exp_q.push_back(model_out());
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_col", int'(col_count_o), 0);
    chk("async_row", int'(row_count_o), 0);
    chk("async_locked", int'(locked_o), 0);
    chk("async_active", int'(active_o), 0);
    chk("async_fcount", int'(frame_count_o), 0);
    chk("async_fstart", int'(frame_start_o), 0);
    chk("async_hsync", int'(Hsync_o), 0);
    chk("async_vsync", int'(Vsync_o), 0);
    drive(0, 1);
    repeat (40) drive(0, 0);
    repeat (3) frame(LEN, 0);

    @(negedge clk_i);
    @(negedge clk_i);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_tracker.md
Name: vga_sync_tracker

Overview:
- Parametrised VGA timing tracker that follows an external Hsync/Vsync pair and delays it one cycle so it stays aligned with the outputs.
- Regenerates column/row counters, an active-video flag, a frame counter and a frame-start strobe.
- Adds a lock state machine that qualifies the incoming frame length before downstream pixel logic (pong game, renderer) trusts the counters.
- Sits between the VGA sync generator and the pixel/graphics pipeline.

Parameters:
- TOTAL_COLS, 800, pixel clocks per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_COLS, 640, visible columns, starting at column 0
- ACTIVE_ROWS, 480, visible rows, starting at row 0
- COL_W, 10, column counter width; must satisfy 2^COL_W >= TOTAL_COLS
- ROW_W, 10, row counter width; must satisfy 2^ROW_W >= TOTAL_ROWS
- FRAME_W, 8, frame counter width
- LOCK_FRAMES, 2, consecutive good frames required to lock; range 1..15

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  asynchronous, active-high reset
- Hsync_i  in  1  incoming horizontal sync
- Vsync_i  in  1  incoming vertical sync
- Hsync_o  out  1  Hsync_i delayed one cycle
- Vsync_o  out  1  Vsync_i delayed one cycle
- col_count_o  out  COL_W  current column
- row_count_o  out  ROW_W  current row
- active_o  out  1  visible-pixel flag
- frame_count_o  out  FRAME_W  count of locked frames
- frame_start_o  out  1  one-cycle strobe for an accepted frame start
- locked_o  out  1  tracker is locked

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting rst_i at any time clears all outputs and all internal state to 0, with state = SEARCH. Operation resumes on the first clock edge after release.
- Sync delay: Hsync_o <= Hsync_i and Vsync_o <= Vsync_i every cycle.
- Edge detect: edge = Vsync_i & ~Vsync_o (combinational). The cycle after an edge, Vsync_o = 1 and the counters read (0,0).
- Free-running count (no edge):
  - col increments by 1.
  - At col = TOTAL_COLS-1, col goes to 0 and row increments.
  - At row = TOTAL_ROWS-1 with col = TOTAL_COLS-1 (the "wrap position"), both counters go to 0.
- On an edge: both counters load 0, in every state. The edge has priority over normal counting.
- Good edge: an edge that occurs while the counters sit exactly at the wrap position and seen_edge = 1.
  - seen_edge is an internal flag, set on the first edge after reset.
  - The first edge after reset is therefore never good.
- State SEARCH:
  - Good edge: good_cnt increments. When good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked_o = 1 on the next cycle.
  - Bad edge: good_cnt resets to 0.
  - Counter wrap with no edge: good_cnt resets to 0.
- State LOCKED:
  - Good edge: stay LOCKED.
  - Bad edge: go to SEARCH, good_cnt = 0, locked_o = 0 on the next cycle. Counters still realign to 0.
  - Wrap position reached with no edge: "missed frame" (behaviour set by the optional feature).
- locked_o is registered and equals (state == LOCKED).
- frame_start_o: registered pulse, 1 for exactly one cycle after any edge accepted while the next state is LOCKED, including the edge that achieves lock. It coincides with counters (0,0).
- frame_count_o: increments by 1 together with every frame_start_o pulse, wraps modulo 2^FRAME_W, and holds its value through loss of lock.
- active_o: combinational, = locked_o & (col_count_o < ACTIVE_COLS) & (row_count_o < ACTIVE_ROWS). Always 0 while in SEARCH.
- Hsync_i is used only by the delay stage; it has no effect on the counters.

Optional Feature:
- Macro: VGA_SYNC_FLYWHEEL_EN
- Defined:
  - In LOCKED, a single missed frame is tolerated. Counters wrap to 0, state stays LOCKED, and the miss flag is set.
  - A second consecutive miss: go to SEARCH.
  - A good edge clears the miss flag.
  - Flywheel wraps do not pulse frame_start_o and do not increment frame_count_o.
- Not defined: any missed frame in LOCKED goes to SEARCH immediately (locked_o = 0 on the next cycle, good_cnt = 0).

Test Plan:
All scenarios use TOTAL_COLS=8, TOTAL_ROWS=4, ACTIVE_COLS=6, ACTIVE_ROWS=3, LOCK_FRAMES=2, FRAME_W=4, so one frame = 32 cycles.
1. Reset, then Vsync_i rising edges every 32 cycles -> locked_o rises the cycle after the 3rd edge; frame_start_o pulses once, with counters (0,0); frame_count_o = 1.
2. Locked; measure active_o over one frame -> high exactly 18 cycles (cols 0..5 on rows 0..2); low at col 6..7 and on row 3.
3. Locked; next edge arrives 5 cycles early (at col 2, row 3) -> locked_o = 0 the next cycle, counters (0,0), active_o = 0; relock requires 2 further good 32-cycle edges.
4. Locked; one edge withheld -> without the macro, locked_o drops after cycle 32 of the missing frame. With VGA_SYNC_FLYWHEEL_EN, locked_o stays 1, counters wrap, frame_count_o is unchanged; a second consecutive miss drops lock.
5. Locked, run 16 frames -> frame_count_o wraps 15 -> 0.
6. Assert rst_i asynchronously mid-frame (counters (3,2)) -> all outputs 0 immediately without a clock edge; after release, counters free-run from 0 and locked_o stays 0.
